alu_result_queue: RTL and testbench
===================================

Name: alu_result_queue

Overview:
- Downstream stage of the N-bit ALU: captures each ALU result together with its flags and opcode into a small FIFO.
- Presents entries to a consumer (writeback/display logic) over a valid/ready handshake.
- Keeps a sticky overflow indicator across results until software clears it.

Parameters:
- N, 5, data width; matches the ALU operand/result width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU result present this cycle
- in_ready  output  1  queue can accept an entry
- in_result  input  N  ALU result
- in_sign  input  1  ALU sign flag
- in_overflow  input  1  ALU overflow flag
- in_status  input  1  ALU status flag (a<=b compare)
- in_op  input  3  opcode that produced the result
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- out_result  output  N  head result
- out_sign, out_overflow, out_status  output  1 each  head flags
- out_op  output  3  head opcode
- count  output  $clog2(DEPTH)+1  occupied entries
- sticky_ovf  output  1  an overflowed entry was accepted since last clear
- sticky_clr  input  1  synchronous clear of sticky_ovf

Behaviour:
- Reset (rst_n low, async): count=0, read/write pointers=0, sticky_ovf=0, out_valid=0, in_ready=1. Storage contents are don't-care. Reset mid-transfer discards all entries.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). No pass-through when full: a simultaneous pop does not make room in the same cycle.
- out_valid = (count != 0). out_* are driven combinationally from the head entry. Stable while out_valid & !out_ready.
- Latency: an entry pushed in cycle T is visible on out_* in cycle T+1 (no fall-through on empty).
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged; write and read pointers both advance
- Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
- Entry order is strictly FIFO. Flags and opcode are stored exactly as received.
- sticky_ovf: set on any push with in_overflow=1; cleared on sticky_clr. Set and clear in the same cycle -> set wins (stays 1).
- Inputs are sampled only on push. in_* are ignored when in_ready=0.

Optional Feature:
- Macro: ALU_RES_SAT_EN
- Defined: on push with in_overflow=1 and in_op equal to ADD (000) or SUB (001), the stored result is saturated before write:
  - in_sign=1 (wrapped negative, true positive) -> stored result {0,1...1}, stored sign 0
  - in_sign=0 -> stored result {1,0...0}, stored sign 1
  - stored overflow stays 1; sticky behaviour unchanged
- Undefined: result stored unmodified (wrap-around).

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_MAX=010, OP_LE=011, OP_AVG=100, OP_SQR=101, OP_ABS=110, OP_SHR=111
  - entry width constant ENTRY_W = N+6 (result, sign, overflow, status, op)
- One sub-module, alu_res_mem: a DEPTH x ENTRY_W register array with one write port and one combinational read port. Pointer, count and flag control stay in alu_result_queue.

Test Plan:
- Reset then idle -> count=0, out_valid=0, in_ready=1, sticky_ovf=0.
- Push 4 entries (results 1,2,3,4; op=000) with out_ready=0 -> count=4, in_ready=0; 5th push (result 5) ignored. Then drain with out_ready=1 -> out_result 1,2,3,4 in order; count returns to 0.
- Queue holds 2 entries, then simultaneous push+pop each cycle for 10 cycles -> count stays 2; outputs in order across pointer wrap.
- Push result 5'b10000 with overflow=1, sign=1, op=000 -> sticky_ovf=1 next cycle. sticky_clr pulsed alone -> 0. sticky_clr in the same cycle as another overflow push -> stays 1.
- With ALU_RES_SAT_EN, push overflow add (sign=1, result 10000) -> out_result=01111, out_sign=0. Push overflow sub (sign=0, result 00110) -> out_result=10000, out_sign=1. Without the macro, results are unchanged.
- Assert rst_n low while count=3 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcode encodings and entry layout.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MAX = 3'b010;
   localparam logic [2:0] OP_LE  = 3'b011;
   localparam logic [2:0] OP_AVG = 3'b100;
   localparam logic [2:0] OP_SQR = 3'b101;
   localparam logic [2:0] OP_ABS = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   // Entry = {result, sign, overflow, status, op}; flags plus opcode take 6 bits.
   localparam int ALU_N        = 5;
   localparam int ENTRY_FLAG_W = 6;
   localparam int ENTRY_W      = ALU_N + ENTRY_FLAG_W;

   function automatic logic is_add_sub(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_res_mem.sv
// DEPTH x W register array: one synchronous write port, one combinational read port.
module alu_res_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 11,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem_q [DEPTH];

   // NOTE: storage is deliberately not reset; validity is tracked by the
   // count in the parent, so resetting the array would only cost flops.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu_result_queue.sv
// FIFO of ALU results with flags/opcode, valid/ready on both sides, sticky overflow.
// Optional macro ALU_RES_SAT_EN: saturate overflowed ADD/SUB results on write.
module alu_result_queue
   import alu_pkg::*;
#(
   parameter int N     = 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_result,
   input  logic                     in_sign,
   input  logic                     in_overflow,
   input  logic                     in_status,
   input  logic [2:0]               in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_result,
   output logic                     out_sign,
   output logic                     out_overflow,
   output logic                     out_status,
   output logic [2:0]               out_op,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     sticky_ovf,
   input  logic                     sticky_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = N + ENTRY_FLAG_W;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          sticky_q, sticky_d;

   logic          push, pop;
   logic [N-1:0]  wr_result;
   logic          wr_sign;
   logic [EW-1:0] wr_data, rd_data;

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      wr_result = in_result;
      wr_sign   = in_sign;
`ifdef ALU_RES_SAT_EN
      if (in_overflow && is_add_sub(in_op)) begin
         // A negative-looking wrap means the true result was a large positive.
         wr_result = in_sign ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
         wr_sign   = ~in_sign;
      end
`endif
      wr_data = {wr_result, wr_sign, in_overflow, in_status, in_op};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Set wins over a same-cycle clear.
      sticky_d = (sticky_q & ~sticky_clr) | (push & in_overflow);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sticky_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         sticky_q <= sticky_d;
      end
   end

   alu_res_mem #(
      .DEPTH (DEPTH),
      .W     (EW),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   assign {out_result, out_sign, out_overflow, out_status, out_op} = rd_data;
   assign count      = count_q;
   assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: directed test-plan items plus random
// traffic against a queue-based model. Honours ALU_RES_SAT_EN when defined.
module tb_alu_result_queue;

   localparam int N     = 5;
   localparam int DEPTH = 4;

   typedef struct {
      logic [N-1:0] result;
      logic         sign;
      logic         ovf;
      logic         status;
      logic [2:0]   op;
   } ent_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] in_result = '0;
   logic         in_sign = 1'b0;
   logic         in_overflow = 1'b0;
   logic         in_status = 1'b0;
   logic [2:0]   in_op = 3'b000;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] out_result;
   logic         out_sign, out_overflow, out_status;
   logic [2:0]   out_op;
   logic [2:0]   count;
   logic         sticky_ovf;
   logic         sticky_clr = 1'b0;

   int   checks = 0;
   int   failures = 0;
   ent_t model_q[$];
   logic sticky_m = 1'b0;

   always #5 clk = ~clk;

   alu_result_queue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_sign      (in_sign),
      .in_overflow  (in_overflow),
      .in_status    (in_status),
      .in_op        (in_op),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_sign     (out_sign),
      .out_overflow (out_overflow),
      .out_status   (out_status),
      .out_op       (out_op),
      .count        (count),
      .sticky_ovf   (sticky_ovf),
      .sticky_clr   (sticky_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // What the queue should store for the current inputs, from the feature rules.
   function automatic ent_t expected_entry();
      ent_t e;
      e.result = in_result;
      e.sign   = in_sign;
      e.ovf    = in_overflow;
      e.status = in_status;
      e.op     = in_op;
`ifdef ALU_RES_SAT_EN
      if (in_overflow && in_op <= 3'd1) begin
         if (in_sign) begin
            e.result = 5'd15;
            e.sign   = 1'b0;
         end else begin
            e.result = 5'd16;
            e.sign   = 1'b1;
         end
      end
`endif
      return e;
   endfunction

   task automatic compare_all();
      check("count", 32'(count), 32'(model_q.size()));
      check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
      check("sticky_ovf", 32'(sticky_ovf), 32'(sticky_m));
      if (model_q.size() != 0) begin
         check("out_result", 32'(out_result), 32'(model_q[0].result));
         check("out_sign", 32'(out_sign), 32'(model_q[0].sign));
         check("out_overflow", 32'(out_overflow), 32'(model_q[0].ovf));
         check("out_status", 32'(out_status), 32'(model_q[0].status));
         check("out_op", 32'(out_op), 32'(model_q[0].op));
      end
   endtask

   // Called at a falling edge with inputs set; advances one clock and checks.
   task automatic cycle();
      bit   push, pop;
      ent_t e;
      push = in_valid && (model_q.size() != DEPTH);
      pop  = out_ready && (model_q.size() != 0);
      e    = expected_entry();
      @(posedge clk);
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(e);
      sticky_m = (sticky_m && !sticky_clr) || (push && in_overflow);
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input logic v, input logic [N-1:0] r, input logic s,
                        input logic o, input logic [2:0] op, input logic rdy);
      in_valid    = v;
      in_result   = r;
      in_sign     = s;
      in_overflow = o;
      in_status   = 1'b0;
      in_op       = op;
      out_ready   = rdy;
   endtask

   task automatic idle_drain();
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive(1'b0, '0, 1'b0, 1'b0, 3'b000, 1'b1);
         cycle();
      end
   endtask

   initial begin
      // Reset, then idle.
      #12;
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_sticky", 32'(sticky_ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Fill to DEPTH, attempt a fifth push, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, N'(i), 1'b0, 1'b0, 3'b000, 1'b0);
         cycle();
      end
      check("full_count", 32'(count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 5'd5, 1'b0, 1'b0, 3'b000, 1'b0);
      cycle();
      check("fifth_ignored_count", 32'(count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         check("drain_order", 32'(out_result), 32'(i));
         drive(1'b0, '0, 1'b0, 1'b0, 3'b000, 1'b1);
         cycle();
      end
      check("drained_count", 32'(count), 32'd0);

      // Two entries resident, then push+pop every cycle across pointer wrap.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, N'(10 + i), 1'b0, 1'b0, 3'b010, 1'b0);
         cycle();
      end
      for (int i = 0; i < 10; i++) begin
         check("stream_head", 32'(out_result), 32'(10 + i));
         drive(1'b1, N'(12 + i), 1'b0, 1'b0, 3'b011, 1'b1);
         cycle();
         check("stream_count", 32'(count), 32'd2);
      end
      idle_drain();

      // Sticky overflow: set, clear alone, then clear racing a new overflow.
      drive(1'b1, 5'b10000, 1'b1, 1'b1, 3'b000, 1'b0);
      cycle();
      check("sticky_set", 32'(sticky_ovf), 32'd1);
      drive(1'b0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
      sticky_clr = 1'b1;
      cycle();
      check("sticky_clr_alone", 32'(sticky_ovf), 32'd0);
      drive(1'b1, 5'b00110, 1'b0, 1'b1, 3'b001, 1'b0);
      cycle();
      sticky_clr = 1'b0;
      check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
      idle_drain();

      // Overflowed ADD/SUB storage (saturated only with the feature enabled).
      drive(1'b1, 5'b10000, 1'b1, 1'b1, 3'b000, 1'b0);
      cycle();
`ifdef ALU_RES_SAT_EN
      check("sat_add_result", 32'(out_result), 32'b01111);
      check("sat_add_sign", 32'(out_sign), 32'd0);
`else
      check("wrap_add_result", 32'(out_result), 32'b10000);
      check("wrap_add_sign", 32'(out_sign), 32'd1);
`endif
      drive(1'b1, 5'b00110, 1'b0, 1'b1, 3'b001, 1'b1);
      cycle();
`ifdef ALU_RES_SAT_EN
      check("sat_sub_result", 32'(out_result), 32'b10000);
      check("sat_sub_sign", 32'(out_sign), 32'd1);
`else
      check("wrap_sub_result", 32'(out_result), 32'b00110);
      check("wrap_sub_sign", 32'(out_sign), 32'd0);
`endif
      check("sat_ovf_kept", 32'(out_overflow), 32'd1);
      idle_drain();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         in_result   = N'($urandom);
         in_sign     = 1'($urandom);
         in_overflow = ($urandom_range(0, 3) == 0);
         in_status   = 1'($urandom);
         in_op       = 3'($urandom);
         out_ready   = ($urandom_range(0, 2) != 0);
         sticky_clr  = ($urandom_range(0, 7) == 0);
         cycle();
      end
      sticky_clr = 1'b0;
      idle_drain();

      // Asynchronous reset with three entries resident.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, N'(20 + i), 1'b0, 1'b1, 3'b100, 1'b0);
         cycle();
      end
      check("pre_reset_count", 32'(count), 32'd3);
      drive(1'b0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_count", 32'(count), 32'd0);
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd1);
      check("async_rst_sticky", 32'(sticky_ovf), 32'd0);
      model_q.delete();
      sticky_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      drive(1'b1, 5'd7, 1'b0, 1'b0, 3'b101, 1'b0);
      cycle();
      check("post_reset_head", 32'(out_result), 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
